apb_master_bridge: RTL and testbench

- Upstream APB requester that drives the APB slave peripheral (clock, reset, address, select, enable, write_en, write_data in; ready, slave_error, read_data back).
- Converts a simple valid/ready request channel and a valid/ready response channel into compliant two-phase APB transfers (SETUP, then ACCESS).
- Adds a wait-state timeout so a hung slave cannot stall the system.

---
 rtl/apb_master_bridge.sv | 155 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Valid/ready request/response channels bridged onto two-phase APB transfers,
// with a configurable ACCESS wait-state timeout so a hung slave cannot stall the system.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  // APB requester side
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  select,
  output logic                  enable,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  ready,
  input  logic                  slave_error,
  input  logic [DATA_WIDTH-1:0] read_data
);

  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   write_en_q, write_en_d;
  logic                   select_q, select_d;
  logic                   enable_q, enable_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_error_q, rsp_error_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

  // A pending unaccepted response blocks new requests, so it is never overwritten.
  assign req_ready = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      address_q     <= '0;
      wdata_q       <= '0;
      write_en_q    <= 1'b0;
      select_q      <= 1'b0;
      enable_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      wdata_q       <= wdata_d;
      write_en_q    <= write_en_d;
      select_q      <= select_d;
      enable_q      <= enable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    wdata_d       = wdata_q;
    write_en_d    = write_en_q;
    select_d      = select_q;
    enable_d      = enable_q;
    rsp_valid_d   = rsp_valid_q && !rsp_ready;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          address_d  = req_addr;
          wdata_d    = req_wdata;
          write_en_d = req_write;
          select_d   = 1'b1;
          enable_d   = 1'b0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        enable_d   = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (ready) begin
          select_d      = 1'b0;
          enable_d      = 1'b0;
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = slave_error;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = write_en_q ? '0 : read_data;
        end else if (TO_EN && (wait_cnt_q == CNT_W'(CNT_LAST))) begin
          // Forced termination: report as an error with no read data.
          select_d      = 1'b0;
          enable_d      = 1'b0;
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        select_d = 1'b0;
        enable_d = 1'b0;
      end
    endcase
  end

  assign address     = address_q;
  assign write_data  = wdata_q;
  assign write_en    = write_en_q;
  assign select      = select_q;
  assign enable      = enable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed scoreboard bench for apb_master_bridge (TIMEOUT=4 instance plus a TIMEOUT=0 instance).
module tb_apb_master_bridge;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wr;
    logic        err;
    logic        to;
    int          lat;
    int          en;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] address, write_data, read_data;
  logic        select, enable, write_en, ready, slave_error;

  logic        req_valid_nt, req_ready_nt, rsp_ready_nt, ready_nt;
  logic        rsp_valid_nt, rsp_error_nt, rsp_timeout_nt;
  logic [31:0] rsp_rdata_nt, address_nt, write_data_nt;
  logic        select_nt, enable_nt, write_en_nt;

  exp_t sb[$];
  exp_t last;
  int   n_chk;
  int   n_fail;

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .address(address), .select(select), .enable(enable), .write_en(write_en),
    .write_data(write_data), .ready(ready), .slave_error(slave_error),
    .read_data(read_data)
  );

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) dut_nt (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_nt), .req_ready(req_ready_nt), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_nt), .rsp_ready(rsp_ready_nt), .rsp_rdata(rsp_rdata_nt),
    .rsp_error(rsp_error_nt), .rsp_timeout(rsp_timeout_nt),
    .address(address_nt), .select(select_nt), .enable(enable_nt), .write_en(write_en_nt),
    .write_data(write_data_nt), .ready(ready_nt), .slave_error(slave_error),
    .read_data(read_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input logic to,
                              input int lat, input int en);
    exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.err = err; e.to = to; e.lat = lat; e.en = en;
    return e;
  endfunction

  // Drive one request through its accept edge, then scramble req_* to prove single sampling.
  task automatic issue(input exp_t e, input bit track);
    if (track) sb.push_back(e);
    req_valid = 1'b1; req_write = e.wr; req_addr = e.addr; req_wdata = e.wdata;
    #1;
    chk("req_ready_before_accept", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0; req_write = ~e.wr; req_addr = ~e.addr; req_wdata = ~e.wdata;
    chk("setup_select", 32'(select), 32'd1);
    chk("setup_enable", 32'(enable), 32'd0);
    chk("setup_address", address, e.addr);
    chk("setup_wdata", write_data, e.wdata);
    chk("setup_write_en", 32'(write_en), 32'(e.wr));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  // Act as the slave until the response appears, then pop and compare the scoreboard entry.
  task automatic await_rsp(input int waits, input logic [31:0] rdata, input logic serr,
                           output exp_t got);
    int   n;
    int   en;
    exp_t e;
    n = 0; en = 0;
    read_data = rdata; slave_error = serr;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    e = (sb.size() > 0) ? sb[0] : mk(1'b0, '0, '0, '0, 1'b0, 1'b0, 0, 0);
    while (!rsp_valid && n < 40) begin
      ready = (waits == 0) ? 1'b1 : ((n + 1) >= (2 + waits));
      step();
      n++;
      if (!rsp_valid) begin
        if (enable) en++;
        chk("select_held", 32'(select), 32'd1);
        chk("address_stable", address, e.addr);
        chk("wdata_stable", write_data, e.wdata);
        chk("write_en_stable", 32'(write_en), 32'(e.wr));
      end
    end
    ready = 1'b0;
    chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("latency", 32'(n), 32'(e.lat));
    chk("enable_cycles", 32'(en), 32'(e.en));
    chk("done_select", 32'(select), 32'd0);
    chk("done_enable", 32'(enable), 32'd0);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_error", 32'(rsp_error), 32'(e.err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
    got = e;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; ready = 1'b0; slave_error = 1'b0; read_data = '0;
    req_valid_nt = 1'b0; rsp_ready_nt = 1'b0; ready_nt = 1'b0;

    #23;
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    step();

    // zero wait states; ready held high in SETUP must be ignored
    ready = 1'b1;
    issue(mk(1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 2, 1), 1'b1);
    await_rsp(0, 32'h0, 1'b0, last);
    ack();
    ready = 1'b1;
    issue(mk(1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 2, 1), 1'b1);
    await_rsp(0, 32'hA5A5A5A5, 1'b0, last);
    ack();

    // three wait states on a write
    issue(mk(1'b1, 32'h1, 32'h12345678, 32'h0, 1'b0, 1'b0, 5, 4), 1'b1);
    await_rsp(3, 32'hFFFFFFFF, 1'b0, last);
    ack();

    // timeout on a hung read; the TIMEOUT=0 instance takes the same request
    req_valid_nt = 1'b1;
    issue(mk(1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1'b1, 5, 4), 1'b1);
    req_valid_nt = 1'b0;
    await_rsp(100, 32'h55AA55AA, 1'b0, last);
    ack();
    for (int i = 0; i < 12; i++) step();
    chk("nt_select_held", 32'(select_nt), 32'd1);
    chk("nt_enable_held", 32'(enable_nt), 32'd1);
    chk("nt_no_rsp", 32'(rsp_valid_nt), 32'd0);

    // wait counter restarts per transfer: TIMEOUT-1 waits still complete
    issue(mk(1'b0, 32'h5, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 5, 4), 1'b1);
    await_rsp(3, 32'h0BADF00D, 1'b0, last);
    ack();

    // slave error on a read, left unaccepted for backpressure
    issue(mk(1'b0, 32'h3, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 2, 1), 1'b1);
    await_rsp(0, 32'hDEADBEEF, 1'b1, last);
    sb.push_back(mk(1'b1, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2, 1));
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, last.rdata);
      chk("bp_rsp_error", 32'(rsp_error), 32'(last.err));
      chk("bp_rsp_timeout", 32'(rsp_timeout), 32'(last.to));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_select", 32'(select), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_req_ready_release", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '1; req_wdata = '0;
    chk("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("bp_select_rise", 32'(select), 32'd1);
    chk("bp_address", address, 32'h4);
    await_rsp(0, 32'h0, 1'b0, last);
    ack();

    // reset asserted between edges during ACCESS
    ready = 1'b0;
    issue(mk(1'b1, 32'h7, 32'h77777777, 32'h0, 1'b0, 1'b0, 2, 1), 1'b0);
    step();
    chk("pre_reset_enable", 32'(enable), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("midrst_select", 32'(select), 32'd0);
    chk("midrst_enable", 32'(enable), 32'd0);
    chk("midrst_write_en", 32'(write_en), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    #10 reset = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_select", 32'(select), 32'd0);
    end
    issue(mk(1'b0, 32'h6, 32'h0, 32'h600DCAFE, 1'b0, 1'b0, 2, 1), 1'b1);
    await_rsp(0, 32'h600DCAFE, 1'b0, last);
    ack();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
